condlogic: RTL and testbench

Conditional-execution unit of the multicycle ARM core. It sits directly downstream of the main control FSM and instruction decoder. It owns the NZCV flags register and gates the FSM's unconditional write strobes (RegW, MemW, PCS) with the instruction's condition field. The result is the architectural write enables that drive the register file, data memory and PC register. A one-cycle condition register holds each instruction's pass/fail verdict stable across its later multicycle states, even after that instruction has updated the flags.

---
 rtl/condlogic_pkg.sv | 26 ++
 rtl/condlogic_if.sv | 26 ++
 rtl/condlogic_condcheck.sv | 40 ++++
 rtl/condlogic.sv | 50 +++++
 tb/tb_condlogic.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/condlogic_pkg.sv
// Shared core definitions: ARM condition mnemonics and NZCV bit positions.
package condlogic_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_if.sv
// Strobe bundle between the control FSM/decoder and the conditional unit.
interface condlogic_if;

    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags
    );

endinterface

// File: rtl/condlogic_condcheck.sv
// Combinational condition evaluator: Cond x NZCV -> pass/fail.
module condcheck
    import condlogic_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       condex_o
);

    logic n, z, c, v, ge;

    assign n  = flags_i[FLAG_N];
    assign z  = flags_i[FLAG_Z];
    assign c  = flags_i[FLAG_C];
    assign v  = flags_i[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        condex_o = 1'b0;
        case (cond_i)
            COND_EQ: condex_o = z;
            COND_NE: condex_o = ~z;
            COND_CS: condex_o = c;
            COND_CC: condex_o = ~c;
            COND_MI: condex_o = n;
            COND_PL: condex_o = ~n;
            COND_VS: condex_o = v;
            COND_VC: condex_o = ~v;
            COND_HI: condex_o = c & ~z;
            COND_LS: condex_o = ~c | z;
            COND_GE: condex_o = ge;
            COND_LT: condex_o = ~ge;
            COND_GT: condex_o = ~z & ge;
            COND_LE: condex_o = z | ~ge;
            COND_AL: condex_o = 1'b1;
            default: condex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: owns NZCV and gates FSM write strobes.
module condlogic
    import condlogic_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    condlogic_if.slave bus
);

    logic       condex;
    logic [1:0] flagwrite;
    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       condex_q;

    condcheck u_condcheck (
        .cond_i   (bus.Cond),
        .flags_i  ({nz_q, cv_q}),
        .condex_o (condex)
    );

    always_comb begin
        flagwrite = bus.FlagW & {2{condex}};
        nz_d      = nz_q;
        cv_d      = cv_q;
        if (flagwrite[1])
            nz_d = bus.ALUFlags[FLAG_N:FLAG_Z];
        if (flagwrite[0])
            cv_d = bus.ALUFlags[FLAG_C:FLAG_V];
    end

    // Verdict is latched every cycle so later states see pre-update flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q     <= 2'b00;
            cv_q     <= 2'b00;
            condex_q <= 1'b0;
        end else begin
            nz_q     <= nz_d;
            cv_q     <= cv_d;
            condex_q <= condex;
        end
    end

    assign bus.Flags    = {nz_q, cv_q};
    assign bus.RegWrite = bus.RegW & condex_q;
    assign bus.MemWrite = bus.MemW & condex_q;
    assign bus.PCWrite  = bus.NextPC | (bus.PCS & condex_q);

endmodule

// File: tb/tb_condlogic.sv
// Directed and random checks of condlogic against a behavioural NZCV model.
module tb_condlogic;
    import condlogic_pkg::*;

    logic clk;
    logic reset;
    int   ntests;
    int   nfail;

    logic [3:0] m_flags;
    bit         m_cexr;

    condlogic_if bus ();

    condlogic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Paired ARM conditions: odd code is the negation of the even one
    function automatic bit ref_pass(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b0;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(string tag);
        chk({tag, ":Flags"}, bus.Flags, m_flags);
        chk({tag, ":RegWrite"}, {3'b0, bus.RegWrite},
            {3'b0, bus.RegW & m_cexr});
        chk({tag, ":MemWrite"}, {3'b0, bus.MemWrite},
            {3'b0, bus.MemW & m_cexr});
        chk({tag, ":PCWrite"}, {3'b0, bus.PCWrite},
            {3'b0, bus.NextPC | (bus.PCS & m_cexr)});
    endtask

    // Called at posedge+1: check, clock, update model, return at posedge+1
    task automatic step(string tag);
        bit p;
        #2;
        check_outs(tag);
        @(posedge clk);
        p = ref_pass(bus.Cond, m_flags);
        if (p && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
        if (p && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
        m_cexr = p;
        #1;
    endtask

    task automatic drive(logic [3:0] c, logic [1:0] fw, logic [3:0] af,
                         logic pcs, logic npc, logic rw, logic mw);
        bus.Cond     = c;
        bus.FlagW    = fw;
        bus.ALUFlags = af;
        bus.PCS      = pcs;
        bus.NextPC   = npc;
        bus.RegW     = rw;
        bus.MemW     = mw;
    endtask

    task automatic lit(string tag, logic [3:0] exp_flags, logic rw,
                       logic mw, logic pw);
        #1;
        chk({tag, ":Flags"}, bus.Flags, exp_flags);
        chk({tag, ":RegWrite"}, {3'b0, bus.RegWrite}, {3'b0, rw});
        chk({tag, ":MemWrite"}, {3'b0, bus.MemWrite}, {3'b0, mw});
        chk({tag, ":PCWrite"}, {3'b0, bus.PCWrite}, {3'b0, pw});
    endtask

    // Verdict check: evaluate cond, then observe it on RegWrite next cycle
    task automatic verdict(string tag, logic [3:0] c, logic exp);
        drive(c, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step({tag, "_eval"});
        drive(COND_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        lit(tag, m_flags, exp, 1'b0, 1'b0);
        step({tag, "_use"});
    endtask

    initial begin
        ntests  = 0;
        nfail   = 0;
        m_flags = 4'h0;
        m_cexr  = 1'b0;
        reset   = 1'b0;
        drive(COND_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        lit("reset_hold", 4'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        lit("post_rst1", 4'h0, 1'b0, 1'b0, 1'b0);
        step("post_rst1");
        lit("post_rst2", 4'h0, 1'b1, 1'b1, 1'b0);
        step("post_rst2");

        drive(COND_AL, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        step("subs");
        drive(COND_EQ, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("subs_flags", 4'b0100, 1'b0, 1'b0, 1'b0);
        step("eq_eval");
        drive(COND_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("eq_pass", 4'b0100, 1'b1, 1'b0, 1'b0);
        step("eq_wb");
        verdict("ne_fail", COND_NE, 1'b0);

        drive(COND_AL, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step("set_all");
        drive(COND_AL, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("split");
        drive(COND_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("split_flags", 4'b0011, 1'b0, 1'b0, 1'b0);
        step("split_chk");

        drive(COND_AL, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("clr");
        drive(COND_EQ, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fail_flagw");
        drive(COND_AL, 2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        lit("fail_gate", 4'b0000, 1'b0, 1'b0, 1'b0);
        step("fail_gate");

        drive(COND_AL, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("set_n");
        verdict("ge_n1v0", COND_GE, 1'b0);
        verdict("lt_n1v0", COND_LT, 1'b1);
        verdict("gt_n1v0", COND_GT, 1'b0);
        verdict("le_n1v0", COND_LE, 1'b1);
        drive(COND_AL, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        step("set_nv");
        verdict("ge_n1v1", COND_GE, 1'b1);
        verdict("gt_n1v1", COND_GT, 1'b1);

        drive(COND_NV, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        lit("nv_npc", 4'b1001, 1'b0, 1'b0, 1'b1);
        step("nv_npc");
        drive(COND_AL, 2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        lit("nv_gate", 4'b1001, 1'b0, 1'b0, 1'b0);
        step("nv_gate");

        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                #1;
                m_flags = 4'h0;
                m_cexr  = 1'b0;
                chk("async_rst:Flags", bus.Flags, 4'h0);
                chk("async_rst:RegWrite", {3'b0, bus.RegWrite}, 4'h0);
                reset = 1'b1;
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
